// File: rtl/alu_pkg.sv
// alu_pkg: opcodes and default datapath width shared by the ALU and its bench.
package alu_pkg;
    localparam int DEFAULT_WIDTH = 32;
    localparam logic [3:0] ADD  = 4'b0000;
    localparam logic [3:0] SUB  = 4'b0001;
    localparam logic [3:0] ADDS = 4'b0010;
    localparam logic [3:0] SUBS = 4'b0011;
    localparam logic [3:0] CMP  = 4'b0100;
    localparam logic [3:0] AND  = 4'b0111;
    localparam logic [3:0] OR   = 4'b1000;
    localparam logic [3:0] XOR  = 4'b1001;
    localparam logic [3:0] MVN  = 4'b1010;
endpackage

// File: rtl/alu_addsub.sv
// alu_addsub: shared adder; subtract is a + ~b + 1 so carry means "no borrow".
module alu_addsub #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sub,
    output logic [WIDTH-1:0] sum,
    output logic             carry,
    output logic             overflow
);
    logic [WIDTH-1:0] w_b;
    assign w_b = sub ? ~b : b;
    assign {carry, sum} = {1'b0, a} + {1'b0, w_b} + {{WIDTH{1'b0}}, sub};
    assign overflow = (a[WIDTH-1] == w_b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
endmodule

// File: rtl/alu_flagged.sv
// alu_flagged: opcode decode, logic ops, and the registered result and NZCV flags.
module alu_flagged
    import alu_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] operand_a,
    input  logic [WIDTH-1:0] operand_b,
    input  logic [3:0]       alu_control,
    output logic [WIDTH-1:0] result,
    output logic             zero_flag,
    output logic             carry_flag,
    output logic             overflow_flag,
    output logic             negative_flag
);
    logic [WIDTH-1:0] w_sum, w_logic, w_val;
    logic w_carry, w_ovf, w_sub, w_arith, w_arith_flags, w_logic_op;
    logic [WIDTH-1:0] r_result;
    logic r_n, r_z, r_c, r_v;

    assign w_sub         = alu_control inside {SUB, SUBS, CMP};
    assign w_arith       = alu_control inside {ADD, SUB, ADDS, SUBS};
    assign w_arith_flags = alu_control inside {ADDS, SUBS, CMP};
    assign w_logic_op    = alu_control inside {AND, OR, XOR, MVN};

    alu_addsub #(.WIDTH(WIDTH)) u_addsub (
        .a(operand_a), .b(operand_b), .sub(w_sub),
        .sum(w_sum), .carry(w_carry), .overflow(w_ovf)
    );

    assign w_logic = (alu_control == AND) ? (operand_a & operand_b) :
                     (alu_control == OR)  ? (operand_a | operand_b) :
                     (alu_control == XOR) ? (operand_a ^ operand_b) : ~operand_a;
    assign w_val = w_logic_op ? w_logic : w_sum;

    // CMP updates flags only; undefined opcodes fall through every enable and hold.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_result <= '0;
            r_n      <= 1'b0;
            r_z      <= 1'b0;
            r_c      <= 1'b0;
            r_v      <= 1'b0;
        end else begin
            if (w_arith || w_logic_op) r_result <= w_val;
            if (w_arith_flags || w_logic_op) begin
                r_n <= w_val[WIDTH-1];
                r_z <= (w_val == '0);
            end
            if (w_arith_flags) begin
                r_c <= w_carry;
                r_v <= w_ovf;
            end
        end
    end

    assign result        = r_result;
    assign negative_flag = r_n;
    assign zero_flag     = r_z;
    assign carry_flag    = r_c;
    assign overflow_flag = r_v;
endmodule

// File: tb/tb_alu_flagged.sv
// tb_alu_flagged: scoreboard bench; a reference model queues expected {result,NZCV} per operation.
module tb_alu_flagged;
    import alu_pkg::*;

    typedef struct packed {
        logic [31:0] res;
        logic [3:0]  f;
    } exp_t;

    typedef struct packed {
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;
        logic [3:0]  f;
    } step_t;

    logic        clk, rst;
    logic [31:0] operand_a, operand_b, result;
    logic [3:0]  alu_control;
    logic        zero_flag, carry_flag, overflow_flag, negative_flag;

    exp_t        sb[$];
    logic [31:0] m_res;
    logic [3:0]  m_f;
    int          checks = 0;
    int          errors = 0;

    alu_flagged #(.WIDTH(32)) dut (
        .clk(clk), .rst(rst),
        .operand_a(operand_a), .operand_b(operand_b), .alu_control(alu_control),
        .result(result), .zero_flag(zero_flag), .carry_flag(carry_flag),
        .overflow_flag(overflow_flag), .negative_flag(negative_flag)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    function automatic logic [35:0] observed();
        return {result, negative_flag, zero_flag, carry_flag, overflow_flag};
    endfunction

    // Reference model: flag bits are {N,Z,C,V}; subtract carry uses an unsigned compare.
    task automatic model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        logic [32:0] s;
        logic [31:0] r;
        case (op)
            ADD: m_res = a + b;
            SUB: m_res = a - b;
            ADDS: begin
                s = {1'b0, a} + {1'b0, b};
                r = s[31:0];
                m_res = r;
                m_f = {r[31], r == 0, s[32], (a[31] == b[31]) && (r[31] != a[31])};
            end
            SUBS, CMP: begin
                r = a - b;
                if (op == SUBS) m_res = r;
                m_f = {r[31], r == 0, a >= b, (a[31] != b[31]) && (r[31] != a[31])};
            end
            AND, OR, XOR, MVN: begin
                r = (op == AND) ? a & b : (op == OR) ? a | b : (op == XOR) ? a ^ b : ~a;
                m_res = r;
                m_f = {r[31], r == 0, m_f[1:0]};
            end
            default: ;
        endcase
    endtask

    task automatic drive(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        alu_control = op;
        operand_a   = a;
        operand_b   = b;
        model(op, a, b);
        sb.push_back('{res: m_res, f: m_f});
    endtask

    task automatic test_reset();
        exp_t e;
        rst = 1'b0;
        alu_control = ADD;
        operand_a = 32'd7;
        operand_b = 32'd9;
        #1 rst = 1'b1;
        #1;
        checks++;
        if (observed() !== 36'h0) begin
            errors++;
            $display("FAIL reset_async: got %h want %h", observed(), 36'h0);
        end
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (observed() !== 36'h0) begin
            errors++;
            $display("FAIL reset_hold: got %h want %h", observed(), 36'h0);
        end
        @(negedge clk) rst = 1'b0;
        m_res = '0;
        m_f = '0;
        drive(ADDS, 32'hFFFF_FFFF, 32'd1);
        @(posedge clk);
        #1;
        e = sb.pop_front();
        checks++;
        if (observed() !== {e.res, e.f}) begin
            errors++;
            $display("FAIL reset_release: got %h want %h", observed(), {e.res, e.f});
        end
        drive(ADD, 32'd100, 32'd23);
        #2 rst = 1'b1;
        #1;
        checks++;
        if (observed() !== 36'h0) begin
            errors++;
            $display("FAIL reset_midop: got %h want %h", observed(), 36'h0);
        end
        @(posedge clk);
        #1;
        checks++;
        if (observed() !== 36'h0) begin
            errors++;
            $display("FAIL reset_discard: got %h want %h", observed(), 36'h0);
        end
        sb.delete();
        m_res = '0;
        m_f = '0;
        @(negedge clk) rst = 1'b0;
    endtask

    task automatic test_arith();
        exp_t e;
        step_t tbl[6] = '{
            '{ADD,  32'd10,        32'd20, 32'd30,        4'b0000},
            '{SUB,  32'd30,        32'd15, 32'd15,        4'b0000},
            '{ADDS, 32'h7FFF_FFFF, 32'd1,  32'h8000_0000, 4'b1001},
            '{ADDS, 32'hFFFF_FFFF, 32'd1,  32'h0,         4'b0110},
            '{SUBS, 32'hFFFF_FFF6, 32'd5,  32'hFFFF_FFF1, 4'b1010},
            '{SUBS, 32'd5,         32'd5,  32'h0,         4'b0110}
        };
        for (int i = 0; i < 6; i++) begin
            drive(tbl[i].op, tbl[i].a, tbl[i].b);
            @(posedge clk);
            #1;
            e = sb.pop_front();
            checks++;
            if (observed() !== {e.res, e.f}) begin
                errors++;
                $display("FAIL arith_model[%0d]: got %h want %h", i, observed(), {e.res, e.f});
            end
            checks++;
            if (observed() !== {tbl[i].res, tbl[i].f}) begin
                errors++;
                $display("FAIL arith_const[%0d]: got %h want %h", i, observed(), {tbl[i].res, tbl[i].f});
            end
        end
    endtask

    task automatic test_logic();
        exp_t e;
        step_t tbl[5] = '{
            '{ADDS, 32'h8000_0000, 32'h8000_0000, 32'h0,         4'b0111},
            '{AND,  32'hC,         32'hA,         32'h8,         4'b0011},
            '{OR,   32'hC,         32'hA,         32'hE,         4'b0011},
            '{XOR,  32'hC,         32'hA,         32'h6,         4'b0011},
            '{MVN,  32'hC,         32'hDEAD_BEEF, 32'hFFFF_FFF3, 4'b1011}
        };
        for (int i = 0; i < 5; i++) begin
            drive(tbl[i].op, tbl[i].a, tbl[i].b);
            @(posedge clk);
            #1;
            e = sb.pop_front();
            checks++;
            if (observed() !== {e.res, e.f}) begin
                errors++;
                $display("FAIL logic_model[%0d]: got %h want %h", i, observed(), {e.res, e.f});
            end
            checks++;
            if (observed() !== {tbl[i].res, tbl[i].f}) begin
                errors++;
                $display("FAIL logic_const[%0d]: got %h want %h", i, observed(), {tbl[i].res, tbl[i].f});
            end
        end
    endtask

    task automatic test_cmp_noop();
        exp_t e;
        step_t tbl[5] = '{
            '{ADD,     32'd10, 32'd20, 32'd30, 4'b1011},
            '{CMP,     32'd10, 32'd20, 32'd30, 4'b1000},
            '{4'b1111, 32'd1,  32'd2,  32'd30, 4'b1000},
            '{4'b0101, 32'd0,  32'd0,  32'd30, 4'b1000},
            '{4'b0110, 32'hFF, 32'h1,  32'd30, 4'b1000}
        };
        for (int i = 0; i < 5; i++) begin
            drive(tbl[i].op, tbl[i].a, tbl[i].b);
            @(posedge clk);
            #1;
            e = sb.pop_front();
            checks++;
            if (observed() !== {e.res, e.f}) begin
                errors++;
                $display("FAIL cmp_model[%0d]: got %h want %h", i, observed(), {e.res, e.f});
            end
            checks++;
            if (observed() !== {tbl[i].res, tbl[i].f}) begin
                errors++;
                $display("FAIL cmp_const[%0d]: got %h want %h", i, observed(), {tbl[i].res, tbl[i].f});
            end
        end
    endtask

    task automatic test_back_to_back();
        exp_t e;
        logic [31:0] edge_vals[4] = '{32'h0, 32'hFFFF_FFFF, 32'h7FFF_FFFF, 32'h8000_0000};
        logic [31:0] a, b;
        for (int i = 0; i < 60; i++) begin
            a = (i % 3 == 0) ? edge_vals[$urandom_range(0, 3)] : $urandom;
            b = (i % 4 == 0) ? edge_vals[$urandom_range(0, 3)] : $urandom;
            if (i % 7 == 0) b = a;
            drive(4'($urandom_range(0, 15)), a, b);
            @(posedge clk);
            #1;
            e = sb.pop_front();
            checks++;
            if (observed() !== {e.res, e.f}) begin
                errors++;
                $display("FAIL b2b[%0d] op=%b a=%h b=%h: got %h want %h",
                         i, alu_control, a, b, observed(), {e.res, e.f});
            end
        end
    endtask

    initial begin
        test_reset();
        test_arith();
        test_logic();
        test_cmp_noop();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/alu_flagged.md
Name: alu_flagged

Overview:
- 32-bit integer ALU with registered result and registered NZCV status flags.
- Sits in the execute stage of the ARM7TDMI-style datapath.
- A 4-bit opcode selects the operation: add/subtract (with or without flag update), compare, or bitwise logic.
- Outputs register on the rising clock edge, giving one cycle of latency.

Parameters:
- WIDTH, 32, datapath width of operands and result; flags derive from bit WIDTH-1.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous active-high reset
- operand_a  input  WIDTH  first operand
- operand_b  input  WIDTH  second operand
- alu_control  input  4  opcode
- result  output  WIDTH  registered result
- zero_flag  output  1  registered Z
- carry_flag  output  1  registered C
- overflow_flag  output  1  registered V
- negative_flag  output  1  registered N

Behaviour:
- Reset: clock and reset
  - One clock; reset is asynchronous and active-high.
  - While rst=1, result and all four flags are 0 immediately, independent of clk.
  - Reset asserted mid-operation discards the pending computation.
- Timing:
  - Inputs are sampled at each rising clk edge while rst=0.
  - Outputs reflect those inputs after that edge (latency 1).
  - A new operation is accepted every cycle; there is no handshake.
- Opcodes (result / flags):
  - 0000 ADD: a+b mod 2^WIDTH / flags held.
  - 0001 SUB: a-b mod 2^WIDTH / flags held.
  - 0010 ADDS: a+b / N, Z, C, V updated.
  - 0011 SUBS: a-b / N, Z, C, V updated.
  - 0100 CMP: result held / N, Z, C, V updated from a-b.
  - 0111 AND: a&b / N, Z updated; C, V held.
  - 1000 OR: a|b / N, Z updated; C, V held.
  - 1001 XOR: a^b / N, Z updated; C, V held.
  - 1010 MVN: ~a (operand_b ignored) / N, Z updated; C, V held.
  - 0101, 0110, 1011-1111: undefined; result and all flags held (no-op).
- Flag rules, where r is the computed value:
  - N = r[WIDTH-1].
  - Z = (r == 0).
  - Add: C = carry out of bit WIDTH-1.
  - Add: V = (a[msb]==b[msb]) && (r[msb]!=a[msb]).
  - Subtract: computed as a + ~b + 1.
  - Subtract: C = NOT borrow, i.e. C=1 iff a >= b unsigned.
  - Subtract: V = (a[msb]!=b[msb]) && (r[msb]!=a[msb]).
- Wrap-around: all arithmetic is modulo 2^WIDTH; no saturation.
- Operands may change every cycle; only the values present at the edge matter.

Decomposition:
- Shared package alu_pkg:
  - Opcode localparams: ADD, SUB, ADDS, SUBS, CMP, AND, OR, XOR, MVN.
  - Default WIDTH.
- One combinational sub-module, alu_addsub:
  - Inputs: a, b, sub select.
  - Outputs: sum, carry, overflow.
  - Shared by ADD/SUB/ADDS/SUBS/CMP.
- Top level holds the opcode decode, logic ops and the output/flag registers.

Test Plan:
- Assert rst between clk edges -> result=0 and NZCV=0000 immediately; they remain 0 while rst=1.
- ADD a=10, b=20, then SUB a=30, b=15 -> result 30, then 15, each one edge later; flags stay 0000.
- ADDS 0x7FFFFFFF+1 -> result 0x80000000, N=1 Z=0 C=0 V=1. Then ADDS 0xFFFFFFFF+1 -> result 0, N=0 Z=1 C=1 V=0.
- SUBS a=-10 (0xFFFFFFF6), b=5 -> result 0xFFFFFFF1, N=1 Z=0 C=1 V=0. Then SUBS 5-5 -> result 0, Z=1 C=1.
- Logic ops with C=1, V=1 preloaded; each op held for one edge:
  - AND 0b1100, 0b1010 -> result 0b1000.
  - OR -> result 0b1110.
  - XOR -> result 0b0110.
  - MVN a=0b1100 -> result 0xFFFFFFF3, N=1.
  - C and V stay 1 throughout.
- Preload result=30, then:
  - CMP a=10, b=20 -> result stays 30, N=1 Z=0 C=0 V=0.
  - Then opcode 1111 -> result and flags unchanged.
